// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the binary<->BCD conversion paths.
// Also provides the common digit-validity check.
package bcd_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  localparam int unsigned BCD_DIGITS    = 4;
  localparam int unsigned ITERATIONS    = 16;
  localparam int unsigned CNT_W         = 4;
  localparam int unsigned ENGINE_W      = 16;
  localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;

  function automatic logic has_invalid_digit(input logic [4*BCD_DIGITS-1:0] digits);
    logic bad;
    bad = 1'b0;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (digits[4*i +: 4] > BCD_MAX_DIGIT) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Reverse double-dabble digit correction: a digit that reached 8 or more
// after the right shift had a borrowed ten's half, so remove the excess 3.
module bcd_digit_adjust (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  always_comb begin
    adjusted = (digit >= 4'd8) ? digit - 4'd3 : digit;
  end

endmodule

// File: rtl/bcd_binary_converter.sv
// Sequential 4-digit BCD to binary converter (reverse double-dabble),
// one shift/adjust iteration per clock with a start/busy/done handshake.
module bcd_binary_converter
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [3:0]           thousand,
  input  logic [3:0]           hundred,
  input  logic [3:0]           ten,
  input  logic [3:0]           one,
  output logic                 busy,
  output logic                 done,
  output logic [BIN_WIDTH-1:0] binary,
  output logic                 invalid
);

  state_t                             state;
  logic [CNT_W-1:0]                   cnt;
  logic [4*BCD_DIGITS-1:0]            bcd_reg;
  logic [4*BCD_DIGITS-1:0]            bcd_next;
  logic [ENGINE_W-1:0]                bin_reg;
  logic                               err;
  logic [4*BCD_DIGITS+ENGINE_W-1:0]   shifted;

  assign shifted = {bcd_reg, bin_reg} >> 1;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adjust
    bcd_digit_adjust u_adjust (
      .digit    (shifted[ENGINE_W + 4*g +: 4]),
      .adjusted (bcd_next[4*g +: 4])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      binary  <= '0;
      invalid <= 1'b0;
      cnt     <= '0;
      bcd_reg <= '0;
      bin_reg <= '0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bcd_reg <= {thousand, hundred, ten, one};
            bin_reg <= '0;
            cnt     <= '0;
            err     <= has_invalid_digit({thousand, hundred, ten, one});
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_reg <= bcd_next;
          bin_reg <= shifted[ENGINE_W-1:0];
          cnt     <= cnt + 1'b1;
          // Final iteration: publish the freshly shifted value, not the stale bin_reg.
          if (cnt == CNT_W'(ITERATIONS - 1)) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
            binary  <= err ? '0 : BIN_WIDTH'(shifted[ENGINE_W-1:0]);
            invalid <= err;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_binary_converter.sv
// Directed scoreboard bench for bcd_binary_converter: latency, results,
// invalid digits, ignored starts, mid-run reset and back-to-back operation.
module tb_bcd_binary_converter;

  localparam int unsigned BW    = 20;
  localparam int          BOUND = 40;

  typedef struct {
    logic [31:0] bin;
    logic        inv;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [3:0]    thousand, hundred, ten, one;
  logic          busy, done, invalid;
  logic [BW-1:0] binary;

  exp_t sb[$];
  exp_t last;
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  bcd_binary_converter #(.BIN_WIDTH(BW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .thousand (thousand),
    .hundred  (hundred),
    .ten      (ten),
    .one      (one),
    .busy     (busy),
    .done     (done),
    .binary   (binary),
    .invalid  (invalid)
  );

  function automatic exp_t model(input int d3, input int d2, input int d1, input int d0);
    exp_t e;
    if (d3 > 9 || d2 > 9 || d1 > 9 || d0 > 9) begin
      e.bin = 32'd0;
      e.inv = 1'b1;
    end else begin
      e.bin = 32'(d3 * 1000 + d2 * 100 + d1 * 10 + d0);
      e.inv = 1'b0;
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2,
                            input logic [3:0] d1, input logic [3:0] d0);
    thousand = d3;
    hundred  = d2;
    ten      = d1;
    one      = d0;
  endtask

  task automatic push_current();
    sb.push_back(model(int'(thousand), int'(hundred), int'(ten), int'(one)));
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    check({tag, "_pending"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e    = sb.pop_front();
      last = e;
      check({tag, "_bin"}, 32'(binary), e.bin);
      check({tag, "_inv"}, 32'(invalid), 32'(e.inv));
    end
  endtask

  task automatic wait_done(output int cycles, output int busy_n);
    cycles = 0;
    busy_n = 0;
    do begin
      step();
      cycles++;
      if (busy) busy_n++;
    end while (!done && cycles < BOUND);
  endtask

  task automatic run_conv(input string tag, input logic [3:0] d3, input logic [3:0] d2,
                          input logic [3:0] d1, input logic [3:0] d0);
    int c, b;
    set_digits(d3, d2, d1, d0);
    push_current();
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy_accept"}, 32'(busy), 32'd1);
    set_digits(4'd7, 4'd7, 4'd7, 4'd7);
    wait_done(c, b);
    check({tag, "_latency"}, 32'(c), 32'd16);
    check({tag, "_busy_cycles"}, 32'(b + 1), 32'd16);
    pop_check(tag);
    step();
    check({tag, "_done_clear"}, 32'(done), 32'd0);
    check({tag, "_hold"}, 32'(binary), last.bin);
  endtask

  initial begin
    int c, b;
    rst_n = 1'b0;
    start = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    step();
    step();
    rst_n = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_binary", 32'(binary), 32'd0);
    check("rst_invalid", 32'(invalid), 32'd0);

    run_conv("c9999", 4'd9, 4'd9, 4'd9, 4'd9);
    run_conv("c0000", 4'd0, 4'd0, 4'd0, 4'd0);
    run_conv("c1234", 4'd1, 4'd2, 4'd3, 4'd4);
    run_conv("c0042", 4'd0, 4'd0, 4'd4, 4'd2);
    run_conv("c8051", 4'd8, 4'd0, 4'd5, 4'd1);
    run_conv("bad_ten", 4'd0, 4'd0, 4'hA, 4'd0);
    run_conv("bad_thou", 4'hF, 4'd1, 4'd2, 4'd3);
    run_conv("c0999", 4'd0, 4'd9, 4'd9, 4'd9);

    // Start pulses during a conversion must neither disturb nor queue.
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    push_current();
    start = 1'b1;
    step();
    for (int i = 1; i <= 16; i++) begin
      start = (i == 3 || i == 9);
      if (start) set_digits(4'd5, 4'd5, 4'd5, 4'd5);
      step();
      if (i == 15) check("ign_no_early_done", 32'(done), 32'd0);
    end
    start = 1'b0;
    check("ign_done_at_16", 32'(done), 32'd1);
    pop_check("ign");
    step();
    check("ign_not_queued_busy", 32'(busy), 32'd0);
    check("ign_not_queued_done", 32'(done), 32'd0);

    // Reset in the middle of a conversion discards it.
    set_digits(4'd9, 4'd9, 4'd9, 4'd9);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_binary", 32'(binary), 32'd0);
    check("mrst_invalid", 32'(invalid), 32'd0);
    step();
    check("mrst_stays_idle", 32'(busy), 32'd0);
    run_conv("after_rst", 4'd0, 4'd0, 4'd4, 4'd2);

    // Start held high: back-to-back conversions with a 17-cycle period.
    set_digits(4'd0, 4'd0, 4'd0, 4'd1);
    push_current();
    start = 1'b1;
    step();
    set_digits(4'd0, 4'd0, 4'd0, 4'd2);
    wait_done(c, b);
    check("b2b_first_latency", 32'(c), 32'd16);
    pop_check("b2b_first");
    push_current();
    step();
    check("b2b_done_clear", 32'(done), 32'd0);
    check("b2b_reaccept_busy", 32'(busy), 32'd1);
    check("b2b_hold", 32'(binary), 32'd1);
    start = 1'b0;
    wait_done(c, b);
    check("b2b_period", 32'(c + 1), 32'd17);
    pop_check("b2b_second");
    step();
    check("b2b_final_hold", 32'(binary), 32'd2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
